// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, instruction field
// positions, the add opcode and the queued request payload.
package alu_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEST_LSB  = 14;
    localparam int unsigned DEST_W    = 2;
    localparam int unsigned GROUP_LSB = 12;
    localparam int unsigned GROUP_W   = 2;
    localparam int unsigned OP_LSB    = 10;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned NUM_DEST  = 4;

    // group 00, op 10 over instruction bits [13:10]
    localparam logic [GROUP_W+OP_W-1:0] ADD_OPCODE = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  data0;
        logic [DATA_W-1:0]  data1;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    function automatic logic [DEST_W-1:0] dest_of(input logic [INSTR_W-1:0] instr);
        return instr[DEST_LSB +: DEST_W];
    endfunction

    // group and op fields are contiguous, so compare them as one 4-bit code
    function automatic logic is_add(input logic [INSTR_W-1:0] instr);
        return instr[OP_LSB +: (GROUP_W + OP_W)] == ADD_OPCODE;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Request queue: show-ahead FIFO with synchronous active-low reset.
// Ports: clk, rst_n; push/wr_data write side; pop/rd_data read side (rd_data
// is the current head); full/empty decoded from the occupancy count.
module seq_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences queued instructions into an external ALU one at a time, captures
// the demuxed result, holds it as a response until accepted and keeps the
// per-destination result registers plus a sticky overflow flag.
// Ports: clk, rst_n; req_* request side (req_ready = queue not full);
// alu_* issue to / results from the ALU; rsp_* response handshake;
// res0..res3 result registers; sticky_ovf/flag_clr; busy.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INSTR_W-1:0] req_instr,
    input  logic [DATA_W-1:0]  req_data0,
    input  logic [DATA_W-1:0]  req_data1,
    output logic [INSTR_W-1:0] alu_instruction,
    output logic [DATA_W-1:0]  alu_data0,
    output logic [DATA_W-1:0]  alu_data1,
    input  logic [DATA_W-1:0]  alu_out0,
    input  logic [DATA_W-1:0]  alu_out1,
    input  logic [DATA_W-1:0]  alu_out2,
    input  logic [DATA_W-1:0]  alu_out3,
    input  logic               alu_zero_flag,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DEST_W-1:0]  rsp_dest,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_zero,
    output logic               rsp_ovf,
    output logic [DATA_W-1:0]  res0,
    output logic [DATA_W-1:0]  res1,
    output logic [DATA_W-1:0]  res2,
    output logic [DATA_W-1:0]  res3,
    output logic               sticky_ovf,
    input  logic               flag_clr,
    output logic               busy
);

    state_t            state;
    state_t            state_next;
    logic              pop;
    logic              capture;
    logic              fifo_full;
    logic              fifo_empty;
    req_t              push_word;
    req_t              head;
    logic [DEST_W-1:0] exec_dest;
    logic [DATA_W-1:0] sel_out;
    logic              exec_ovf;
    logic [DATA_W-1:0] res_q [NUM_DEST];

    assign push_word = {req_instr, req_data0, req_data1};
    assign req_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign res0      = res_q[0];
    assign res1      = res_q[1];
    assign res2      = res_q[2];
    assign res3      = res_q[3];

    seq_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (req_valid),
        .wr_data (push_word),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Result selection for the instruction currently presented to the ALU.
    assign exec_dest = dest_of(alu_instruction);
    assign exec_ovf  = is_add(alu_instruction) && alu_overflow;

    always_comb begin
        sel_out = alu_out0;
        case (exec_dest)
            2'd0:    sel_out = alu_out0;
            2'd1:    sel_out = alu_out1;
            2'd2:    sel_out = alu_out2;
            default: sel_out = alu_out3;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, queue pop and result capture strobes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = EXEC;
                    pop        = 1'b1;
                end
            end
            EXEC: begin
                state_next = RESP;
                capture    = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        state_next = EXEC;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue registers, response registers, result file and sticky flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_instruction <= '0;
            alu_data0       <= '0;
            alu_data1       <= '0;
            rsp_valid       <= 1'b0;
            rsp_dest        <= '0;
            rsp_data        <= '0;
            rsp_zero        <= 1'b0;
            rsp_ovf         <= 1'b0;
            sticky_ovf      <= 1'b0;
            for (int i = 0; i < int'(NUM_DEST); i++) res_q[i] <= '0;
        end else begin
            if (pop) begin
                alu_instruction <= head.instr;
                alu_data0       <= head.data0;
                alu_data1       <= head.data1;
            end
            if (capture) begin
                rsp_valid        <= 1'b1;
                rsp_dest         <= exec_dest;
                rsp_data         <= sel_out;
                rsp_zero         <= alu_zero_flag;
                rsp_ovf          <= exec_ovf;
                res_q[exec_dest] <= sel_out;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // A new overflow takes priority over a simultaneous clear.
            if (capture && exec_ovf) sticky_ovf <= 1'b1;
            else if (flag_clr)       sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue depth in entries (power of 2, >=2).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  request word present.
REQ-005 req_ready  output  1  queue can accept (not full).
REQ-006 req_instr  input  16  ALU instruction; [15:14] destination, [13:12] group, [11:10] op.
REQ-007 req_data0, req_data1  input  8 each  operands.
REQ-008 alu_instruction  output  16  drives ALU instruction port.
REQ-009 alu_data0, alu_data1  output  8 each  drive ALU operand ports.
REQ-010 alu_out0..alu_out3  input  8 each  ALU demux outputs.
REQ-011 alu_zero_flag, alu_overflow  input  1 each  ALU flags.
REQ-012 rsp_valid  output  1  result available; rsp_ready  input  1  consumer accepts.
REQ-013 rsp_dest  output  2, rsp_data  output  8, rsp_zero  output  1, rsp_ovf  output  1  result fields.
REQ-014 res0..res3  output  8 each  architectural result registers, indexed by destination.
REQ-015 sticky_ovf  output  1  overflow seen since last clear; flag_clr  input  1  clears it.
REQ-016 busy  output  1  high when state != IDLE or queue non-empty.

Function
REQ-017 Push on edge where req_valid && req_ready; req_ready = !full, combinational from count only; no bypass around the queue.
REQ-018 FSM states IDLE, EXEC, RESP; IDLE -> EXEC when queue non-empty, popping head into alu_instruction/alu_data0/alu_data1 registers.
REQ-019 EXEC lasts exactly one cycle; at its end captures rsp_dest = alu_instruction[15:14], rsp_data = alu_outN with N = rsp_dest, rsp_zero = alu_zero_flag, rsp_ovf = alu_overflow; enters RESP.
REQ-020 Same edge as REQ-019 writes res[rsp_dest] <= selected alu_outN; other res registers unchanged.
REQ-021 rsp_ovf and sticky_ovf set only when captured instruction[13:10] = 4'b0010 (add); otherwise rsp_ovf = 0.
REQ-022 RESP holds rsp_valid = 1 and all rsp_* stable until rsp_ready; on handshake: queue non-empty -> EXEC with pop (back-to-back), else -> IDLE.
REQ-023 Latency: push at edge T into empty queue with FSM IDLE -> rsp_valid high from edge T+2; sustained throughput one result per 2 cycles with rsp_ready held high.
REQ-024 alu_* outputs retain last issued values outside EXEC.
REQ-025 Push and pop on same edge update count by net zero; full queue blocks push, never overwrites.
REQ-026 Read/write pointers wrap modulo FIFO_DEPTH.
REQ-027 flag_clr and an overflow set on the same edge: set wins.

Reset
REQ-028 While rst_n low at an edge: state IDLE, queue empty, rsp_valid 0, rsp_* 0, alu_* 0, res0..res3 0, sticky_ovf 0.
REQ-029 Reset in EXEC or RESP discards the in-flight instruction and all queued entries; no res register write on that edge.
REQ-030 req_ready is 1 during the first cycle after reset release.

Structure
REQ-031 Shared package alu_pkg holds state enum, instruction field positions (DEST, GROUP, OP) and the ADD opcode constant.
REQ-032 Queue is sub-module seq_fifo (parameterised width 32, depth FIFO_DEPTH); FSM and result registers reside in alu_sequencer; ALU instantiated outside.

Verification
REQ-033 Single add: instr 16'h4800 (dest 1, add), data 8'd200/8'd100, ALU model sum -> rsp_valid at T+2, rsp_dest 1, rsp_data 8'd44, rsp_ovf 1, res1 = 8'd44, sticky_ovf 1.
REQ-034 Back-to-back: push 4 instructions, rsp_ready high -> 4 responses at T+2, T+4, T+6, T+8; req_ready low only while count = 4.
REQ-035 Backpressure: rsp_ready low 10 cycles -> rsp_* stable, queue fills, req_ready 0, no push accepted; release drains in order.
REQ-036 Flags: flag_clr pulsed in same cycle as overflowing add capture -> sticky_ovf remains 1; next-cycle flag_clr alone -> 0.
REQ-037 Reset mid-RESP with 2 queued -> next cycle rsp_valid 0, busy 0, res0..res3 0, req_ready 1.
